axi_sum_accumulator: RTL and testbench

//  Downstream consumer of the 8-bit adder's 16-bit sum stream. Accumulates
//  LEN consecutive sums into one wide total. Emits the total on an
//  AXI-Stream-style valid/ready output, with a per-packet saturation flag.

---
 rtl/axi_sum_accumulator.sv | 84 ++++++++
 tb/tb_axi_sum_accumulator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/axi_sum_accumulator.sv
// axi_sum_accumulator: sums LEN consecutive 16-bit input beats into one saturating ACC_W-bit total
// and presents it with an overflow flag on a valid/ready output.
module axi_sum_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      s_axis_data,
    input  logic             s_axis_valid,
    output logic             s_axis_ready,
    output logic [ACC_W-1:0] m_axis_data,
    output logic             m_axis_valid,
    input  logic             m_axis_ready,
    output logic             m_axis_ovf
);
    localparam int CW = LEN > 1 ? $clog2(LEN) : 1;

    typedef enum logic {ACCUM, OUTPUT} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, movf_q, movf_d;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] sat;

    always_comb begin
        sum     = {1'b0, acc_q} + (ACC_W+1)'(s_axis_data);
        // an earlier saturation in this packet pins the result at full scale
        carry   = sum[ACC_W] | ovf_q;
        sat     = carry ? '1 : sum[ACC_W-1:0];
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        movf_d  = movf_q;
        case (state_q)
            ACCUM: if (s_axis_valid) begin
                if (cnt_q == CW'(LEN-1)) begin
                    data_d  = sat;
                    movf_d  = carry;
                    state_d = OUTPUT;
                end else begin
                    acc_d = sat;
                    cnt_d = cnt_q + 1'b1;
                    ovf_d = carry;
                end
            end
            OUTPUT: if (m_axis_ready) begin
                state_d = ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            movf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            movf_q  <= movf_d;
        end
    end

    assign s_axis_ready = state_q == ACCUM;
    assign m_axis_valid = state_q == OUTPUT;
    assign m_axis_data  = data_q;
    assign m_axis_ovf   = movf_q;
endmodule

// File: tb/tb_axi_sum_accumulator.sv
// tb_axi_sum_accumulator: three configurations (LEN=4/ACC_W=24, LEN=4/ACC_W=17, LEN=1/ACC_W=24)
// driven with directed packets; per-instance scoreboards check every output handshake.
module tb_axi_sum_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data  [3];
    logic        s_valid [3];
    logic        s_ready [3];
    logic        m_valid [3];
    logic        m_ready [3];
    logic        m_ovf   [3];
    logic [23:0] m_data  [3];
    logic [23:0] md0, md2;
    logic [16:0] md1;
    logic [24:0] sbq [3][$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    axi_sum_accumulator #(.LEN(4), .ACC_W(24)) dut_a (
        .clk(clk), .rst(rst), .s_axis_data(s_data[0]), .s_axis_valid(s_valid[0]),
        .s_axis_ready(s_ready[0]), .m_axis_data(md0), .m_axis_valid(m_valid[0]),
        .m_axis_ready(m_ready[0]), .m_axis_ovf(m_ovf[0]));

    axi_sum_accumulator #(.LEN(4), .ACC_W(17)) dut_s (
        .clk(clk), .rst(rst), .s_axis_data(s_data[1]), .s_axis_valid(s_valid[1]),
        .s_axis_ready(s_ready[1]), .m_axis_data(md1), .m_axis_valid(m_valid[1]),
        .m_axis_ready(m_ready[1]), .m_axis_ovf(m_ovf[1]));

    axi_sum_accumulator #(.LEN(1), .ACC_W(24)) dut_1 (
        .clk(clk), .rst(rst), .s_axis_data(s_data[2]), .s_axis_valid(s_valid[2]),
        .s_axis_ready(s_ready[2]), .m_axis_data(md2), .m_axis_valid(m_valid[2]),
        .m_axis_ready(m_ready[2]), .m_axis_ovf(m_ovf[2]));

    assign m_data[0] = md0;
    assign m_data[1] = {7'b0, md1};
    assign m_data[2] = md2;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : mon
        always @(negedge clk) begin
            if (!rst && m_valid[g] && m_ready[g]) begin
                if (sbq[g].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output dut%0d: got 0x%0h expected none", g, m_data[g]);
                end else begin
                    chk($sformatf("out_dut%0d", g), {7'b0, m_ovf[g], m_data[g]}, {7'b0, sbq[g].pop_front()});
                end
            end
        end
    end

    task automatic send(int k, logic [15:0] d);
        int n = 0;
        @(negedge clk);
        s_valid[k] = 1'b1;
        s_data[k]  = d;
        while (!s_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready[k]) chk("send_timeout", 32'(s_ready[k]), 32'd1);
        @(posedge clk);
        #1;
        s_valid[k] = 1'b0;
    endtask

    task automatic chk_reset_vals(int k);
        chk($sformatf("rst_s_ready%0d", k), 32'(s_ready[k]), 32'd1);
        chk($sformatf("rst_m_valid%0d", k), 32'(m_valid[k]), 32'd0);
        chk($sformatf("rst_m_data%0d", k), 32'(m_data[k]), 32'd0);
        chk($sformatf("rst_m_ovf%0d", k), 32'(m_ovf[k]), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            s_data[k]  = '0;
            s_valid[k] = 1'b0;
            m_ready[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_reset_vals(k);
        rst = 1'b0;

        // basic packet, total one cycle after the 4th beat
        m_ready[0] = 1'b1;
        sbq[0].push_back({1'b0, 24'd10});
        send(0, 16'd1); send(0, 16'd2); send(0, 16'd3); send(0, 16'd4);
        chk("latency_valid", 32'(m_valid[0]), 32'd1);
        chk("latency_data", 32'(m_data[0]), 32'd10);
        repeat (3) @(posedge clk);

        // backpressure with ignored input while the total is pending
        m_ready[0] = 1'b0;
        sbq[0].push_back({1'b0, 24'd26});
        send(0, 16'd5); send(0, 16'd6); send(0, 16'd7); send(0, 16'd8);
        s_valid[0] = 1'b1;
        s_data[0]  = 16'd999;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(m_valid[0]), 32'd1);
            chk("stall_data", 32'(m_data[0]), 32'd26);
            chk("stall_s_ready", 32'(s_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", 32'(m_valid[0]), 32'd0);
        chk("release_s_ready", 32'(s_ready[0]), 32'd1);

        // saturation at 17 bits, then a clean packet
        m_ready[1] = 1'b1;
        sbq[1].push_back({1'b1, 24'h01FFFF});
        sbq[1].push_back({1'b0, 24'd4});
        repeat (4) send(1, 16'hFFFF);
        repeat (4) send(1, 16'd1);
        repeat (3) @(posedge clk);

        // idle gaps between beats
        sbq[0].push_back({1'b0, 24'd1000});
        send(0, 16'd100); repeat (2) @(posedge clk);
        send(0, 16'd200);
        send(0, 16'd300); repeat (3) @(posedge clk);
        send(0, 16'd400);
        repeat (3) @(posedge clk);

        // asynchronous reset discards a partial packet
        send(0, 16'd5); send(0, 16'd6);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals(0);
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals(0);
        rst = 1'b0;
        sbq[0].push_back({1'b0, 24'd4});
        repeat (4) send(0, 16'd1);
        repeat (3) @(posedge clk);

        // LEN=1 pass-through with one bubble per packet
        m_ready[2] = 1'b1;
        sbq[2].push_back({1'b0, 24'd7});
        sbq[2].push_back({1'b0, 24'd8});
        send(2, 16'd7);
        chk("len1_bubble_s_ready", 32'(s_ready[2]), 32'd0);
        chk("len1_valid", 32'(m_valid[2]), 32'd1);
        chk("len1_data", 32'(m_data[2]), 32'd7);
        @(posedge clk);
        #1;
        chk("len1_reopen", 32'(s_ready[2]), 32'd1);
        send(2, 16'd8);
        repeat (5) @(posedge clk);

        for (int k = 0; k < 3; k++) chk($sformatf("sb_empty%0d", k), 32'(sbq[k].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
